// File: rtl/decode_stage_v2.sv
// MIPS decode stage: one-entry valid/ready pipeline register with register-file read,
// early resolution of BEQ/BNE/J/JAL/JR and wrong-path fetch squashing by target PC match.
module decode_stage_v2 #(
  parameter int XLEN          = 32,
  parameter int ENABLE_BNE    = 1,
  parameter int ENABLE_JAL_JR = 1,
  parameter int DELAY_SLOT    = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [31:0]     in_instr_i,
  output logic [4:0]      rs_addr_o,
  output logic [4:0]      rt_addr_o,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_instr_o,
  output logic [5:0]      out_op_o,
  output logic [5:0]      out_func_o,
  output logic [4:0]      out_rd_o,
  output logic [XLEN-1:0] out_rs_word_o,
  output logic [XLEN-1:0] out_rt_word_o,
  output logic [XLEN-1:0] out_imm_sext_o,
  output logic            out_link_o,
  output logic [XLEN-1:0] out_link_addr_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [1:0] {RUN, SLOT, SQUASH} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   target_q, target_d;

  logic              fireIn, fireOut, latch, taken;
  logic              isBeq, isBne, isJ, isJal, isJr;
  logic [XLEN-1:0]   pcPlus4, pcPlus8, immSext, targetPc;

  assign in_ready_o  = !valid_q | out_ready_i;
  assign fireIn      = in_valid_i & in_ready_o;
  assign fireOut     = valid_q & out_ready_i;
  assign out_valid_o = valid_q;

  assign rs_addr_o      = instr_q[25:21];
  assign rt_addr_o      = instr_q[20:16];
  assign out_pc_o       = pc_q;
  assign out_instr_o    = instr_q;
  assign out_op_o       = instr_q[31:26];
  assign out_func_o     = instr_q[5:0];
  assign out_rd_o       = instr_q[15:11];
  assign out_rs_word_o  = rs_data_i;
  assign out_rt_word_o  = rt_data_i;
  assign immSext        = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
  assign out_imm_sext_o = immSext;

  assign pcPlus4 = pc_q + XLEN'(4);
  assign pcPlus8 = pc_q + XLEN'(8);

  assign isBeq = (instr_q[31:26] == 6'h04);
  assign isBne = (ENABLE_BNE != 0) && (instr_q[31:26] == 6'h05);
  assign isJ   = (instr_q[31:26] == 6'h02);
  assign isJal = (ENABLE_JAL_JR != 0) && (instr_q[31:26] == 6'h03);
  assign isJr  = (ENABLE_JAL_JR != 0) && (instr_q[31:26] == 6'h00) && (instr_q[5:0] == 6'h08);

  assign taken = (isBeq && (rs_data_i == rt_data_i)) || (isBne && (rs_data_i != rt_data_i))
                 || isJ || isJal || isJr;

  always_comb begin
    targetPc = pcPlus4 + {immSext[XLEN-3:0], 2'b00};
    if (isJ || isJal) targetPc = {pcPlus4[XLEN-1:28], instr_q[25:0], 2'b00};
    else if (isJr)    targetPc = rs_data_i;
  end

  // Link data is gated by valid so an empty stage presents all-zero data
  assign out_link_o       = valid_q & isJal;
  assign out_link_addr_o  = !valid_q ? '0 : ((DELAY_SLOT != 0) ? pcPlus8 : pcPlus4);
  assign redirect_valid_o = valid_q & taken & out_ready_i & !flush_i;
  assign redirect_pc_o    = redirect_valid_o ? targetPc : '0;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    target_d = target_q;
    latch    = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      // A beat arriving with a redirect is the delay slot when slots exist, wrong-path otherwise
      if (redirect_valid_o) begin
        target_d = targetPc;
        if (DELAY_SLOT != 0) begin
          latch   = fireIn;
          state_d = fireIn ? SQUASH : SLOT;
        end else begin
          state_d = SQUASH;
        end
      end else begin
        case (state_q)
          RUN:  latch = fireIn;
          SLOT: begin
            latch = fireIn;
            if (fireIn) state_d = SQUASH;
          end
          SQUASH: begin
            if (fireIn && (in_pc_i == target_q)) begin
              latch   = 1'b1;
              state_d = RUN;
            end
          end
          default: state_d = RUN;
        endcase
      end
      if (latch) begin
        valid_d = 1'b1;
        pc_d    = in_pc_i;
        instr_d = in_instr_i;
      end else if (fireOut) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      instr_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2: table of single-instruction decode vectors plus
// hand-written squash, delay-slot, stall, flush and async-reset sequences.
module tb_decode_stage_v2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic [31:0] inPc, inInstr, rsData, rtData;
  logic        outReady;

  // Outputs of the DELAY_SLOT=0 instance
  logic        inReady0, outValid0, outLink0, redirValid0;
  logic [4:0]  rsAddr0, rtAddr0, outRd0;
  logic [5:0]  outOp0, outFunc0;
  logic [31:0] outPc0, outInstr0, outRsWord0, outRtWord0, outImm0, linkAddr0, redirPc0;

  // Outputs of the DELAY_SLOT=1 instance
  logic        inReady1, outValid1, outLink1, redirValid1;
  logic [4:0]  rsAddr1, rtAddr1, outRd1;
  logic [5:0]  outOp1, outFunc1;
  logic [31:0] outPc1, outInstr1, outRsWord1, outRtWord1, outImm1, linkAddr1, redirPc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_v2 #(.XLEN(32), .ENABLE_BNE(1), .ENABLE_JAL_JR(1), .DELAY_SLOT(0)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady0),
    .in_pc_i(inPc), .in_instr_i(inInstr), .rs_addr_o(rsAddr0), .rt_addr_o(rtAddr0),
    .rs_data_i(rsData), .rt_data_i(rtData), .out_valid_o(outValid0), .out_ready_i(outReady),
    .out_pc_o(outPc0), .out_instr_o(outInstr0), .out_op_o(outOp0), .out_func_o(outFunc0),
    .out_rd_o(outRd0), .out_rs_word_o(outRsWord0), .out_rt_word_o(outRtWord0),
    .out_imm_sext_o(outImm0), .out_link_o(outLink0), .out_link_addr_o(linkAddr0),
    .redirect_valid_o(redirValid0), .redirect_pc_o(redirPc0));

  decode_stage_v2 #(.XLEN(32), .ENABLE_BNE(1), .ENABLE_JAL_JR(1), .DELAY_SLOT(1)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(inReady1),
    .in_pc_i(inPc), .in_instr_i(inInstr), .rs_addr_o(rsAddr1), .rt_addr_o(rtAddr1),
    .rs_data_i(rsData), .rt_data_i(rtData), .out_valid_o(outValid1), .out_ready_i(outReady),
    .out_pc_o(outPc1), .out_instr_o(outInstr1), .out_op_o(outOp1), .out_func_o(outFunc1),
    .out_rd_o(outRd1), .out_rs_word_o(outRsWord1), .out_rt_word_o(outRtWord1),
    .out_imm_sext_o(outImm1), .out_link_o(outLink1), .out_link_addr_o(linkAddr1),
    .redirect_valid_o(redirValid1), .redirect_pc_o(redirPc1));

  typedef struct {
    string       name;
    logic [31:0] pc, instr, rs, rt;
    logic        expRedir;
    logic [31:0] expRpc;
    logic        expLink;
    logic [31:0] expLinkAddr, expImm;
  } vec_t;

  vec_t vecs[12];

  localparam logic [31:0] ADD = 32'h00221820;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    inValid = 1'b1;
    inPc    = pc;
    inInstr = instr;
  endtask

  // One vector: clear the stage with a flush, load while stalled, then release
  task automatic applyStimulus(input vec_t v);
    waitCycle();
    flush = 1'b1; inValid = 1'b0; outReady = 1'b1;
    waitCycle();
    flush = 1'b0; offer(v.pc, v.instr); rsData = v.rs; rtData = v.rt; outReady = 1'b0;
    waitCycle();
    inValid = 1'b0;
    #1;
    checkOutput({v.name, ".valid"}, 32'(outValid0), 32'd1);
    checkOutput({v.name, ".stallRedir"}, 32'(redirValid0), 32'd0);
    checkOutput({v.name, ".instr"}, outInstr0, v.instr);
    checkOutput({v.name, ".rsAddr"}, 32'(rsAddr0), 32'(v.instr[25:21]));
    outReady = 1'b1;
    #1;
    checkOutput({v.name, ".redir"}, 32'(redirValid0), 32'(v.expRedir));
    checkOutput({v.name, ".redirPc"}, redirPc0, v.expRpc);
    checkOutput({v.name, ".link"}, 32'(outLink0), 32'(v.expLink));
    checkOutput({v.name, ".linkAddr"}, linkAddr0, v.expLinkAddr);
    checkOutput({v.name, ".imm"}, outImm0, v.expImm);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{"add",     32'h00000040, ADD,          32'd1,      32'd2, 1'b0, 32'h0,        1'b0, 32'h00000044, 32'h00001820};
    vecs[1]  = '{"beqT",    32'h00000100, 32'h10220003, 32'd5,      32'd5, 1'b1, 32'h110,      1'b0, 32'h00000104, 32'h00000003};
    vecs[2]  = '{"beqN",    32'h00000100, 32'h10220003, 32'd5,      32'd6, 1'b0, 32'h0,        1'b0, 32'h00000104, 32'h00000003};
    vecs[3]  = '{"beqNeg",  32'h00000200, 32'h1022FFFE, 32'd7,      32'd7, 1'b1, 32'h1FC,      1'b0, 32'h00000204, 32'hFFFFFFFE};
    vecs[4]  = '{"bneT",    32'h00000300, 32'h14220010, 32'd5,      32'd6, 1'b1, 32'h344,      1'b0, 32'h00000304, 32'h00000010};
    vecs[5]  = '{"bneN",    32'h00000300, 32'h14220010, 32'd9,      32'd9, 1'b0, 32'h0,        1'b0, 32'h00000304, 32'h00000010};
    vecs[6]  = '{"j",       32'h00400020, 32'h08100000, 32'd0,      32'd0, 1'b1, 32'h00400000, 1'b0, 32'h00400024, 32'h00000000};
    vecs[7]  = '{"jal",     32'h00001000, 32'h0C000040, 32'd0,      32'd0, 1'b1, 32'h00000100, 1'b1, 32'h00001004, 32'h00000040};
    vecs[8]  = '{"jr",      32'h00002000, 32'h03E00008, 32'h1234,   32'd0, 1'b1, 32'h00001234, 1'b0, 32'h00002004, 32'h00000008};
    vecs[9]  = '{"jalHi",   32'hF0000000, 32'h0C000010, 32'd0,      32'd0, 1'b1, 32'hF0000040, 1'b1, 32'hF0000004, 32'h00000010};
    vecs[10] = '{"beqWrap", 32'hFFFFFFFC, 32'h10220000, 32'd3,      32'd3, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
    vecs[11] = '{"func9",   32'h00002100, 32'h03E00009, 32'h1234,   32'd0, 1'b0, 32'h0,        1'b0, 32'h00002104, 32'h00000009};

    rstN = 1'b0; flush = 1'b0; inValid = 1'b0; inPc = '0; inInstr = '0;
    rsData = '0; rtData = '0; outReady = 1'b1;

    // Reset state
    #12;
    checkOutput("rst.valid", 32'(outValid0), 32'd0);
    checkOutput("rst.redir", 32'(redirValid0), 32'd0);
    checkOutput("rst.pc", outPc0, 32'd0);
    checkOutput("rst.instr", outInstr0, 32'd0);
    checkOutput("rst.linkAddr", linkAddr0, 32'd0);
    checkOutput("rst.redirPc", redirPc0, 32'd0);
    rstN = 1'b1;

    // Straight-line stream, one instruction per cycle
    waitCycle();
    offer(32'h0, ADD);
    #1 checkOutput("run.inReady", 32'(inReady0), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      waitCycle();
      if (i < 3) offer(32'(i * 4), ADD); else inValid = 1'b0;
      #1;
      checkOutput("run.valid", 32'(outValid0), 32'd1);
      checkOutput("run.pc", outPc0, 32'((i - 1) * 4));
      checkOutput("run.redir", 32'(redirValid0), 32'd0);
    end

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // DELAY_SLOT=0: taken BEQ drops 0x104/0x108, keeps target 0x110
    waitCycle(); flush = 1'b1; inValid = 1'b0; outReady = 1'b1;
    waitCycle(); flush = 1'b0; offer(32'h100, 32'h10220003); rsData = 5; rtData = 5;
    waitCycle(); offer(32'h104, ADD);
    #1 checkOutput("sq.redir", 32'(redirValid0), 32'd1);
    checkOutput("sq.redirPc", redirPc0, 32'h110);
    waitCycle(); offer(32'h108, ADD);
    #1 checkOutput("sq.drop104", 32'(outValid0), 32'd0);
    checkOutput("sq.noRepulse", 32'(redirValid0), 32'd0);
    waitCycle(); offer(32'h110, ADD);
    #1 checkOutput("sq.drop108", 32'(outValid0), 32'd0);
    waitCycle(); inValid = 1'b0;
    #1 checkOutput("sq.tgtValid", 32'(outValid0), 32'd1);
    checkOutput("sq.tgtPc", outPc0, 32'h110);

    // Same BEQ not taken: fall-through is kept
    waitCycle(); offer(32'h100, 32'h10220003); rtData = 6;
    waitCycle(); offer(32'h104, ADD);
    #1 checkOutput("nt.redir", 32'(redirValid0), 32'd0);
    waitCycle(); inValid = 1'b0;
    #1 checkOutput("nt.valid", 32'(outValid0), 32'd1);
    checkOutput("nt.pc", outPc0, 32'h104);

    // DELAY_SLOT=1: J with slot coinciding with the redirect
    waitCycle(); flush = 1'b1; inValid = 1'b0;
    waitCycle(); flush = 1'b0; offer(32'h00400020, 32'h08100000);
    waitCycle(); offer(32'h00400024, ADD);
    #1 checkOutput("ds.redir", 32'(redirValid1), 32'd1);
    checkOutput("ds.redirPc", redirPc1, 32'h00400000);
    checkOutput("ds.linkAddr", linkAddr1, 32'h00400028);
    waitCycle(); offer(32'h00400028, ADD);
    #1 checkOutput("ds.slotValid", 32'(outValid1), 32'd1);
    checkOutput("ds.slotPc", outPc1, 32'h00400024);
    waitCycle(); offer(32'h00400000, ADD);
    #1 checkOutput("ds.drop", 32'(outValid1), 32'd0);
    waitCycle(); inValid = 1'b0;
    #1 checkOutput("ds.tgtValid", 32'(outValid1), 32'd1);
    checkOutput("ds.tgtPc", outPc1, 32'h00400000);

    // DELAY_SLOT=1: slot arrives a cycle after the redirect
    waitCycle(); flush = 1'b1;
    waitCycle(); flush = 1'b0; offer(32'h00400020, 32'h08100000);
    waitCycle(); inValid = 1'b0;
    waitCycle(); offer(32'h00400024, ADD);
    waitCycle(); offer(32'h00400028, ADD);
    #1 checkOutput("ds2.slotPc", outPc1, 32'h00400024);
    waitCycle(); inValid = 1'b0;
    #1 checkOutput("ds2.drop", 32'(outValid1), 32'd0);

    // JR held under back-pressure pulses once, on release
    waitCycle(); flush = 1'b1;
    waitCycle(); flush = 1'b0; offer(32'h3000, 32'h03E00008); rsData = 32'h1234; rtData = 0; outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      waitCycle(); offer(32'h3004, ADD);
      #1 checkOutput("jr.stallRedir", 32'(redirValid0), 32'd0);
      checkOutput("jr.inReady", 32'(inReady0), 32'd0);
      checkOutput("jr.heldPc", outPc0, 32'h3000);
      checkOutput("jr.heldInstr", outInstr0, 32'h03E00008);
    end
    waitCycle(); inValid = 1'b0; outReady = 1'b1;
    #1 checkOutput("jr.redir", 32'(redirValid0), 32'd1);
    checkOutput("jr.redirPc", redirPc0, 32'h1234);
    waitCycle();
    #1 checkOutput("jr.once", 32'(redirValid0), 32'd0);

    // Flush while squashing returns to RUN and drops the incoming beat
    waitCycle(); offer(32'h100, 32'h10220003); rsData = 5; rtData = 5;
    waitCycle(); inValid = 1'b0;
    waitCycle(); flush = 1'b1; offer(32'h110, ADD);
    #1 checkOutput("fl.redirForced", 32'(redirValid0), 32'd0);
    waitCycle(); flush = 1'b0; offer(32'h500, ADD);
    #1 checkOutput("fl.valid", 32'(outValid0), 32'd0);
    waitCycle(); inValid = 1'b0;
    #1 checkOutput("fl.runPc", outPc0, 32'h500);
    checkOutput("fl.runValid", 32'(outValid0), 32'd1);

    // Async reset while a redirect is being presented
    waitCycle(); offer(32'h600, 32'h10220003); outReady = 1'b0;
    waitCycle(); inValid = 1'b0; outReady = 1'b1;
    #1 checkOutput("ar.redirBefore", 32'(redirValid0), 32'd1);
    #2 rstN = 1'b0;
    #1 checkOutput("ar.valid", 32'(outValid0), 32'd0);
    checkOutput("ar.redir", 32'(redirValid0), 32'd0);
    #1 rstN = 1'b1;
    waitCycle(); offer(32'h700, ADD);
    waitCycle(); inValid = 1'b0;
    #1 checkOutput("ar.runPc", outPc0, 32'h700);
    checkOutput("ar.runValid", 32'(outValid0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
